dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared data memory (combinational read, write on `posedge clk`). Port 0 is the CPU load/store path. Port 1 is a secondary master, such as a DMA or test loader. Each access is a two-cycle IDLE→ACCESS sequence: requests are sampled and latched in IDLE, and the memory is driven from the latched values in ACCESS. Read data is returned registered, one cycle after grant.

---
 rtl/dmem_arbiter.sv | 159 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the shared data memory: IDLE latches the winning request, ACCESS drives it.
// Optional starvation override for port 1 is built only when DMEM_ARB_STARVE_EN is defined.
module dmem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0] mem_wd,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rd
);

    // state     | meaning
    // ST_IDLE   | sample requests, latch winner's command
    // ST_ACCESS | drive memory from latched command, pulse winner's gnt
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic                  win_q, win_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] p0_rdata_q, p0_rdata_d;
    logic [DATA_WIDTH-1:0] p1_rdata_q, p1_rdata_d;
    logic                  p0_rvalid_q, p0_rvalid_d;
    logic                  p1_rvalid_q, p1_rvalid_d;

    logic any_req;
    logic p1_wins;
    logic access;

    assign any_req = p0_req | p1_req;
    assign access  = (state_q == ST_ACCESS);

`ifdef DMEM_ARB_STARVE_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_q, starve_d;
    logic             starve_hit;

    assign starve_hit = (starve_q == CNT_MAX);
    assign p1_wins    = p1_req & (~p0_req | starve_hit);

    // Counts only arbitrations port 1 actually lost; saturates so the override stays armed.
    always_comb begin
        starve_d = starve_q;
        if ((state_q == ST_IDLE) && any_req) begin
            if (p1_wins) begin
                starve_d = '0;
            end else if (p1_req && !starve_hit) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign p1_wins = p1_req & ~p0_req;
`endif

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        p0_rdata_d  = p0_rdata_q;
        p1_rdata_d  = p1_rdata_q;
        p0_rvalid_d = 1'b0;
        p1_rvalid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_ACCESS;
                    win_d   = p1_wins;
                    we_d    = p1_wins ? p1_we    : p0_we;
                    addr_d  = p1_wins ? p1_addr  : p0_addr;
                    wdata_d = p1_wins ? p1_wdata : p0_wdata;
                end
            end
            ST_ACCESS: begin
                state_d = ST_IDLE;
                if (!we_q) begin
                    if (win_q) begin
                        p1_rvalid_d = 1'b1;
                        p1_rdata_d  = mem_rd;
                    end else begin
                        p0_rvalid_d = 1'b1;
                        p0_rdata_d  = mem_rd;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            win_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
            p0_rvalid_q <= p0_rvalid_d;
            p1_rvalid_q <= p1_rvalid_d;
        end
    end

    // Strobes derive from state_q so an async reset in ACCESS kills mem_we before the next edge.
    assign p0_gnt    = access & ~win_q;
    assign p1_gnt    = access & win_q;
    assign mem_we    = access & we_q;
    assign mem_a     = addr_q;
    assign mem_wd    = wdata_q;
    assign p0_rvalid = p0_rvalid_q;
    assign p1_rvalid = p1_rvalid_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_dmem_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SL = 4;
`ifdef DMEM_ARB_STARVE_EN
    localparam int EXP_FIRST_P1 = 5;
`else
    localparam int EXP_FIRST_P1 = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          p0_req, p1_req, p0_we, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd, mem_rd;
    logic          mem_we;

    logic [DW-1:0] mem [256] = '{default: 32'h0BAD_F00D};

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[7:0]];
    always @(posedge clk) if (mem_we) mem[mem_a[7:0]] <= mem_wd;

    dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
    );

    // Reference model: word store keyed by address, pending request per port, read-data per port.
    logic [31:0] exp_mem [bit [31:0]];
    logic [31:0] exp_rd [2];
    bit          pend [2];
    bit          pwe [2];
    logic [31:0] pad [2];
    logic [31:0] pdt [2];
    int          starve_cnt;
    int          n_pass;
    int          n_fail;
    int          n_total;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : 32'h0BAD_F00D;
    endfunction

    task automatic drive_inputs();
        p0_req = pend[0]; p0_we = pwe[0]; p0_addr = pad[0]; p0_wdata = pdt[0];
        p1_req = pend[1]; p1_we = pwe[1]; p1_addr = pad[1]; p1_wdata = pdt[1];
    endtask

    task automatic set_req(input int p, input bit we, input logic [31:0] a, input logic [31:0] d);
        pend[p] = 1'b1; pwe[p] = we; pad[p] = a; pdt[p] = d;
    endtask

    function automatic int model_pick();
        bit starve_go;
        starve_go = 1'b0;
`ifdef DMEM_ARB_STARVE_EN
        starve_go = pend[1] && (starve_cnt >= SL);
`endif
        if (pend[1] && (!pend[0] || starve_go)) return 1;
        return 0;
    endfunction

    // One arbitration round: starts in an IDLE cycle at negedge, ends at negedge of the rvalid cycle.
    task automatic step_arb(output int got);
        int          w;
        bit          we_w;
        logic [31:0] a, d;
        got = -1;
        drive_inputs();
        if (!pend[0] && !pend[1]) begin
            @(posedge clk); @(negedge clk);
            chk("idle_gnt", {p0_gnt, p1_gnt}, 2'b00);
            chk("idle_mem_we", mem_we, 1'b0);
            return;
        end
        w = model_pick();
        if (w == 1) starve_cnt = 0;
        else if (pend[1] && starve_cnt < SL) starve_cnt++;
        a = pad[w]; we_w = pwe[w]; d = pdt[w];
        @(posedge clk); @(negedge clk);
        got = p1_gnt ? 1 : (p0_gnt ? 0 : -1);
        chk("gnt", {p0_gnt, p1_gnt}, (w == 0) ? 2'b10 : 2'b01);
        chk("mem_we", mem_we, we_w);
        chk("mem_a", mem_a, a);
        chk("mem_wd", mem_wd, d);
        pend[w] = 1'b0;
        drive_inputs();
        @(posedge clk); @(negedge clk);
        if (we_w) exp_mem[a] = d;
        else exp_rd[w] = mem_model(a);
        chk("rvalid", {p0_rvalid, p1_rvalid}, we_w ? 2'b00 : ((w == 0) ? 2'b10 : 2'b01));
        chk("rdata0", p0_rdata, exp_rd[0]);
        chk("rdata1", p1_rdata, exp_rd[1]);
        chk("post_gnt_we", {p0_gnt, p1_gnt, mem_we}, 3'b000);
        chk("hold_mem_a", mem_a, a);
    endtask

    initial begin
        int got, first_p1;
        n_pass = 0; n_fail = 0; n_total = 0; starve_cnt = 0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; pwe[p] = 1'b0; pad[p] = '0; pdt[p] = '0;
        end
        drive_inputs();
        rst_n = 1'b0;

        // Reset then idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_we", mem_we, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_strobes", {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_we}, 5'b00000);
            chk("rst_rdata", {p0_rdata, p1_rdata}, 64'h0);
            chk("rst_mem_a", mem_a, 32'h0);
            chk("rst_mem_wd", mem_wd, 32'h0);
        end

        // Port 0 write then read
        set_req(0, 1'b1, 32'h0001_0010, 32'hDEAD_BEEF);
        step_arb(got);
        set_req(0, 1'b0, 32'h0001_0010, 32'h0);
        step_arb(got);
        chk("p0_rd_deadbeef", p0_rdata, 32'hDEAD_BEEF);

        // Simultaneous reads, distinct words
        set_req(0, 1'b1, 32'h0001_0000, 32'h1111_1111);
        step_arb(got);
        set_req(0, 1'b1, 32'h0001_0004, 32'h2222_2222);
        step_arb(got);
        set_req(0, 1'b0, 32'h0001_0000, 32'h0);
        set_req(1, 1'b0, 32'h0001_0004, 32'h0);
        step_arb(got);
        chk("simul_first", got, 0);
        step_arb(got);
        chk("simul_second", got, 1);
        chk("simul_p0_word", p0_rdata, 32'h1111_1111);
        chk("simul_p1_word", p1_rdata, 32'h2222_2222);

        // Starvation: p0 continuous, p1 holding
        first_p1 = 0;
        set_req(1, 1'b0, 32'h0001_0010, 32'h0);
        for (int i = 1; i <= 20; i++) begin
            if (!pend[0]) set_req(0, 1'b0, 32'h0001_0000, 32'h0);
            step_arb(got);
            if (got == 1 && first_p1 == 0) first_p1 = i;
        end
        chk("starve_first_p1", first_p1, EXP_FIRST_P1);
        pend[0] = 1'b0; pend[1] = 1'b0;
        step_arb(got);

        // Reset during a port 1 write
        set_req(1, 1'b1, 32'h0001_0020, 32'h1234_5678);
        drive_inputs();
        @(posedge clk); #2;
        chk("rstw_gnt", p1_gnt, 1'b1);
        chk("rstw_we_before", mem_we, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rstw_we_after", mem_we, 1'b0);
        chk("rstw_gnt_after", p1_gnt, 1'b0);
        pend[1] = 1'b0;
        drive_inputs();
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        starve_cnt = 0; exp_rd[0] = '0; exp_rd[1] = '0;
        @(negedge clk);
        chk("rstw_no_resp", {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid}, 4'b0000);
        chk("rstw_rdata", {p0_rdata, p1_rdata}, 64'h0);
        set_req(0, 1'b0, 32'h0001_0020, 32'h0);
        step_arb(got);
        chk("rstw_unchanged", p0_rdata, 32'h0BAD_F00D);

        // Request dropped in ACCESS
        set_req(1, 1'b0, 32'h0001_0010, 32'h0);
        step_arb(got);
        chk("drop_gnt_once", got, 1);
        chk("drop_rdata", p1_rdata, 32'hDEAD_BEEF);
        step_arb(got);
        chk("drop_no_dup", got, -1);

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) != 0)
                    set_req(p, 1'($urandom_range(0, 1)),
                            32'h0001_0000 + ($urandom_range(0, 15) << 2), $urandom);
            end
            step_arb(got);
        end
        pend[0] = 1'b0; pend[1] = 1'b0;
        step_arb(got);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
